// File: rtl/bin_dec_scan.sv
// N-to-2^N one-hot decoder with registered outputs and a built-in index sequencer
// that supports direct decode, up/down scanning and single-cycle strobes.
`timescale 1ns/1ps
module bin_dec_scan #(
  parameter int N        = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [N-1:0]     a,
  output logic [2**N-1:0]  bcode,
  output logic [N-1:0]     idx,
  output logic             wrap
);
  localparam int W   = 2**N;
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  localparam logic [1:0] MODE_DIRECT    = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
  localparam logic [1:0] MODE_PULSE     = 2'b11;

  logic [N-1:0]   idx_reg, idx_next;
  logic [PCW-1:0] pc_reg, pc_next;
  logic [W-1:0]   bcode_reg, bcode_next;
  logic           wrap_reg, wrap_next;
  logic [1:0]     mode_reg;
  logic           active_reg;
  logic           show;
  logic           restart;
  logic           tick;
  logic [N-1:0]   step_idx;

  // The decoded output always reflects the index being written this edge.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_dec
      assign bcode_next[gi] = show && (idx_next == N'(gi));
    end
  endgenerate

  always_comb begin
    idx_next  = idx_reg;
    pc_next   = '0;
    wrap_next = 1'b0;
    show      = 1'b0;
    // A fresh enable or a mode switch restarts the step period from zero.
    restart   = !active_reg || (mode != mode_reg);
    tick      = (pc_reg == PC_LAST);
    step_idx  = (mode == MODE_SCAN_DOWN) ? idx_reg - 1'b1 : idx_reg + 1'b1;
    if (en) begin
      case (mode)
        MODE_DIRECT: begin
          idx_next = a;
          show     = 1'b1;
        end
        MODE_PULSE: begin
          if (load) begin
            idx_next = a;
            show     = 1'b1;
          end
        end
        default: begin
          show = 1'b1;
          if (load) begin
            idx_next = a;
          end else if (restart) begin
            pc_next = '0;
          end else if (tick) begin
            idx_next  = step_idx;
            wrap_next = (mode == MODE_SCAN_UP) ? (idx_reg == '1) : (idx_reg == '0);
          end else begin
            pc_next = pc_reg + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg    <= '0;
      pc_reg     <= '0;
      bcode_reg  <= '0;
      wrap_reg   <= 1'b0;
      mode_reg   <= MODE_DIRECT;
      active_reg <= 1'b0;
    end else begin
      idx_reg    <= idx_next;
      pc_reg     <= pc_next;
      bcode_reg  <= bcode_next;
      wrap_reg   <= wrap_next;
      mode_reg   <= mode;
      active_reg <= en;
    end
  end

  assign bcode = bcode_reg;
  assign idx   = idx_reg;
  assign wrap  = wrap_reg;

endmodule

// File: tb/tb_bin_dec_scan.sv
// Scoreboard bench for bin_dec_scan across four parameter sets sharing one stimulus bus.
`timescale 1ns/1ps
module tb_bin_dec_scan;

  typedef struct packed {
    logic [63:0] bcode;
    logic [5:0]  idx;
    logic        wrap;
  } rec_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [5:0] a6;

  logic [15:0] bc0, bc1;
  logic [3:0]  ix0, ix1;
  logic [3:0]  bc2;
  logic [1:0]  ix2;
  logic [63:0] bc3;
  logic [5:0]  ix3;
  logic        wr0, wr1, wr2, wr3;

  int tests_run = 0;
  int failed    = 0;
  rec_t sb[$];

  bin_dec_scan #(.N(4), .PRESCALE(4)) u_n4p4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .a(a6[3:0]),
    .bcode(bc0), .idx(ix0), .wrap(wr0));
  bin_dec_scan #(.N(4), .PRESCALE(1)) u_n4p1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .a(a6[3:0]),
    .bcode(bc1), .idx(ix1), .wrap(wr1));
  bin_dec_scan #(.N(2), .PRESCALE(2)) u_n2p2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .a(a6[1:0]),
    .bcode(bc2), .idx(ix2), .wrap(wr2));
  bin_dec_scan #(.N(6), .PRESCALE(3)) u_n6p3 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .a(a6),
    .bcode(bc3), .idx(ix3), .wrap(wr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input logic [63:0] b, input int i, input logic w);
    rec_t r;
    r.bcode = b;
    r.idx   = 6'(i);
    r.wrap  = w;
    return r;
  endfunction

  function automatic rec_t onehot(input int i, input logic w);
    logic [63:0] one;
    one = 64'd1;
    return mk(one << i, i, w);
  endfunction

  function automatic rec_t obs(input int k);
    rec_t r;
    case (k)
      0:       r = mk(64'(bc0), int'(ix0), wr0);
      1:       r = mk(64'(bc1), int'(ix1), wr1);
      2:       r = mk(64'(bc2), int'(ix2), wr2);
      default: r = mk(bc3, int'(ix3), wr3);
    endcase
    return r;
  endfunction

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic l, input int av);
    @(negedge clk);
    reset = r;
    en    = e;
    mode  = m;
    load  = l;
    a6    = 6'(av);
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rec_t got, exp;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 0);
    edge_settle();
    drive(1'b1, 1'b1, 2'b01, 1'b1, 5);
    for (int k = 0; k < 4; k++) sb.push_back(mk(64'd0, 0, 1'b0));
    edge_settle();
    for (int k = 0; k < 4; k++) begin
      exp = sb.pop_front();
      got = obs(k);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL reset[dut%0d]: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
                 k, got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
      end
    end
  endtask

  task automatic test_direct();
    rec_t got, exp;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 2'b00, i[0], i);
      sb.push_back(onehot(i, 1'b0));
      edge_settle();
      exp = sb.pop_front();
      got = obs(0);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL direct[a=%0d]: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
                 i, got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
      end
    end
  endtask

  task automatic test_scan_up();
    rec_t got, exp;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 0);
    sb.push_back(mk(64'd0, 0, 1'b0));
    edge_settle();
    exp = sb.pop_front();
    got = obs(0);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL scan_up_reset: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
               got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
    end
    // Edge 1 is the first with en high; steps land every 4 edges after it.
    for (int e = 1; e <= 70; e++) begin
      drive(1'b0, 1'b1, 2'b01, 1'b0, 0);
      sb.push_back(onehot(((e - 1) / 4) % 16, (e > 1) && ((e - 1) % 64 == 0)));
      edge_settle();
      exp = sb.pop_front();
      got = obs(0);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL scan_up[edge %0d]: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
                 e, got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
      end
    end
  endtask

  task automatic test_scan_down();
    rec_t got, exp;
    int seq [6] = '{2, 1, 0, 15, 14, 13};
    for (int s = 0; s < 6; s++) begin
      drive(1'b0, 1'b1, 2'b10, (s == 0), 2);
      sb.push_back(onehot(seq[s], (s == 3)));
      edge_settle();
      exp = sb.pop_front();
      got = obs(1);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL scan_down[step %0d]: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
                 s, got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
      end
    end
  endtask

  task automatic test_pulse();
    rec_t got, exp;
    for (int s = 0; s < 6; s++) begin
      if (s == 0) begin
        drive(1'b0, 1'b1, 2'b11, 1'b1, 5);
        sb.push_back(onehot(5, 1'b0));
      end else if (s == 1) begin
        drive(1'b0, 1'b1, 2'b11, 1'b1, 9);
        sb.push_back(onehot(9, 1'b0));
      end else begin
        drive(1'b0, 1'b1, 2'b11, 1'b0, 3);
        sb.push_back(mk(64'd0, 9, 1'b0));
      end
      edge_settle();
      exp = sb.pop_front();
      got = obs(0);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL pulse[step %0d]: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
                 s, got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
      end
    end
  endtask

  task automatic test_en_gap();
    rec_t got, exp;
    // Load 7, run two edges, drop en for three, restore; step due 4 edges after restore.
    for (int s = 1; s <= 12; s++) begin
      drive(1'b0, !(s >= 4 && s <= 6), 2'b01, (s == 1), 7);
      if (s >= 4 && s <= 6) sb.push_back(mk(64'd0, 7, 1'b0));
      else                  sb.push_back(onehot((s >= 11) ? 8 : 7, 1'b0));
      edge_settle();
      exp = sb.pop_front();
      got = obs(0);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL en_gap[edge %0d]: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
                 s, got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
      end
    end
  endtask

  task automatic test_corner(input int k, input int n, input int p);
    rec_t got, exp;
    int last;
    last = (1 << n) - 1;
    // Edge 0 loads the top index, the next p-1 edges count, edge p would wrap but loads 1.
    for (int s = 0; s <= p + 3; s++) begin
      if (s == 0) begin
        drive(1'b0, 1'b1, 2'b01, 1'b1, last);
        sb.push_back(onehot(last, 1'b0));
      end else if (s < p) begin
        drive(1'b0, 1'b1, 2'b01, 1'b0, 0);
        sb.push_back(onehot(last, 1'b0));
      end else if (s == p) begin
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1);
        sb.push_back(onehot(1, 1'b0));
      end else if (s == p + 1) begin
        drive(1'b0, 1'b1, 2'b01, 1'b0, 0);
        sb.push_back(onehot(1, 1'b0));
      end else if (s == p + 2) begin
        drive(1'b1, 1'b1, 2'b01, 1'b0, 0);
        sb.push_back(mk(64'd0, 0, 1'b0));
      end else begin
        drive(1'b0, 1'b0, 2'b01, 1'b0, 0);
        sb.push_back(mk(64'd0, 0, 1'b0));
      end
      edge_settle();
      exp = sb.pop_front();
      got = obs(k);
      tests_run++;
      if (got !== exp) begin
        failed++;
        $display("FAIL corner_n%0d[edge %0d]: got bcode=%h idx=%0d wrap=%b, want bcode=%h idx=%0d wrap=%b",
                 n, s, got.bcode, got.idx, got.wrap, exp.bcode, exp.idx, exp.wrap);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    mode  = 2'b00;
    load  = 1'b0;
    a6    = '0;
    test_reset();
    test_direct();
    test_scan_up();
    test_scan_down();
    test_pulse();
    test_en_gap();
    test_corner(0, 4, 4);
    test_corner(2, 2, 2);
    test_corner(3, 6, 3);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
